// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : issue_ctrl
// Description : Dispatch controller between the instruction queue/decoder and
//               the back-end buffers (ROB, reservation station, store/load
//               buffer). Tracks free-entry credits for each buffer, decides
//               every cycle whether the decoded head instruction may issue,
//               and sequences the blocked window that follows a mispredict
//               flush.
// Ports       : clk, rst (async, active-high)
//               rdy                       - global enable, freezes all state
//               flush                     - mispredict flush level from ROB
//               is_empty_from_instr_queue - head of instruction queue invalid
//               is_sl_from_dc             - head is load/store (SLB) else RS
//               rob/rs/slb_release        - one entry freed in that buffer
//               pop_to_instr_queue        - head consumed (== issue)
//               issue_to_rob/rs/slb       - allocation strobes
//               stall                     - head valid but not issued
//               rob_credit                - free ROB entries
//               perf_issue_cnt/perf_stall_cnt (ISSUE_PERF_CNT_EN only)
// Options     : define ISSUE_PERF_CNT_EN to add the 32-bit issue/stall
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
    parameter int ROB_DEPTH      = 16,
    parameter int RS_DEPTH       = 16,
    parameter int SLB_DEPTH      = 16,
    parameter int CNT_WIDTH      = 5,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic                 is_empty_from_instr_queue,
    input  logic                 is_sl_from_dc,
    input  logic                 rob_release,
    input  logic                 rs_release,
    input  logic                 slb_release,
    output logic                 pop_to_instr_queue,
    output logic                 issue_to_rob,
    output logic                 issue_to_rs,
    output logic                 issue_to_slb,
    output logic                 stall,
    output logic [CNT_WIDTH-1:0] rob_credit
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] c_ROB_FULL = CNT_WIDTH'(ROB_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_RS_FULL  = CNT_WIDTH'(RS_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_SLB_FULL = CNT_WIDTH'(SLB_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_ONE      = CNT_WIDTH'(1);

    // Issue is blocked for RECOVER_CYCLES cycles after flush falls. The first
    // of those is the FLUSH state itself (credits being refilled), so RECOVER
    // only has to cover the remaining RECOVER_CYCLES-1 cycles. With one or
    // zero cycles requested there is nothing left for RECOVER to do.
    localparam bit          c_HAS_RECOVER = (RECOVER_CYCLES > 1);
    localparam int          c_REC_W       = (RECOVER_CYCLES > 2) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [c_REC_W-1:0] c_REC_LOAD =
        c_REC_W'((RECOVER_CYCLES > 1) ? RECOVER_CYCLES - 1 : 0);
    localparam logic [c_REC_W-1:0] c_REC_ONE  = c_REC_W'(1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_REC_W-1:0]   r_rec_cnt;
    logic [c_REC_W-1:0]   w_rec_next;
    logic [c_REC_W-1:0]   w_rec_dec;

    logic [CNT_WIDTH-1:0] r_rob_credit;
    logic [CNT_WIDTH-1:0] r_rs_credit;
    logic [CNT_WIDTH-1:0] r_slb_credit;

    logic                 w_buf_ok;
    logic                 w_can_issue;
    logic                 w_stall;
    logic                 w_refill;

    // Credit step: one entry taken on issue, one returned on release.
    // A release into an already-full buffer is a protocol violation and is
    // absorbed so the counter never exceeds the buffer depth.
    function automatic logic [CNT_WIDTH-1:0] f_credit_next(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 take,
        input logic                 give,
        input logic [CNT_WIDTH-1:0] full
    );
        logic [CNT_WIDTH-1:0] nxt;
        nxt = cur;
        if (take && !give) begin
            nxt = cur - c_ONE;
        end else if (give && !take && (cur != full)) begin
            nxt = cur + c_ONE;
        end
        return nxt;
    endfunction

    // ------------------------------------------------------------------
    // Issue decision (zero latency). rst gates the strobes so the outputs
    // drop the moment reset is asserted, not at the next clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_buf_ok    = is_sl_from_dc ? (r_slb_credit != '0) : (r_rs_credit != '0);
        w_can_issue = !rst && rdy && (r_state == ST_RUN) && !flush &&
                      !is_empty_from_instr_queue && (r_rob_credit != '0) && w_buf_ok;
        w_stall     = !rst && rdy && !is_empty_from_instr_queue && !w_can_issue;
    end

    assign pop_to_instr_queue = w_can_issue;
    assign issue_to_rob       = w_can_issue;
    assign issue_to_rs        = w_can_issue && !is_sl_from_dc;
    assign issue_to_slb       = w_can_issue && is_sl_from_dc;
    assign stall              = w_stall;
    assign rob_credit         = r_rob_credit;

    // Back-end buffers are emptied by the same flush, so credits snap back to
    // full both while flush is high and during the FLUSH state that follows.
    assign w_refill  = flush || (r_state == ST_FLUSH);
    assign w_rec_dec = r_rec_cnt - c_REC_ONE;

    // ------------------------------------------------------------------
    // Flush / recovery sequencing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rec_next   = r_rec_cnt;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!flush) begin
                    if (c_HAS_RECOVER) begin
                        w_state_next = ST_RECOVER;
                        w_rec_next   = c_REC_LOAD;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RECOVER: begin
                if (flush) begin
                    w_state_next = ST_FLUSH;
                end else if (w_rec_dec == '0) begin
                    // Counter reaching zero ends the blocked window.
                    w_state_next = ST_RUN;
                    w_rec_next   = '0;
                end else begin
                    w_rec_next   = w_rec_dec;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_rec_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_rec_cnt    <= '0;
            r_rob_credit <= c_ROB_FULL;
            r_rs_credit  <= c_RS_FULL;
            r_slb_credit <= c_SLB_FULL;
        end else if (rdy) begin
            r_state   <= w_state_next;
            r_rec_cnt <= w_rec_next;
            if (w_refill) begin
                r_rob_credit <= c_ROB_FULL;
                r_rs_credit  <= c_RS_FULL;
                r_slb_credit <= c_SLB_FULL;
            end else begin
                r_rob_credit <= f_credit_next(r_rob_credit, w_can_issue, rob_release, c_ROB_FULL);
                r_rs_credit  <= f_credit_next(r_rs_credit, issue_to_rs, rs_release, c_RS_FULL);
                r_slb_credit <= f_credit_next(r_slb_credit, issue_to_slb, slb_release, c_SLB_FULL);
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    // Both strobes already include rdy, so the counters freeze with it.
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_can_issue) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_ctrl
// Description : Self-checking bench for issue_ctrl. A credit/blocking model
//               predicts every output on each falling edge; directed phases
//               add literal expectations for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_issue_ctrl;

    localparam int c_DEPTH = 16;
    localparam int c_RC    = 2;
    localparam int c_CW    = 5;
    // Cycles issue stays blocked after flush falls (never fewer than one).
    localparam int c_BLOCK = (c_RC > 1) ? c_RC : 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b0;
    logic flush = 1'b0;
    logic empty = 1'b1;
    logic is_sl = 1'b0;
    logic rob_rel = 1'b0;
    logic rs_rel = 1'b0;
    logic slb_rel = 1'b0;

    logic            pop, i_rob, i_rs, i_slb, stall;
    logic [c_CW-1:0] rob_credit;
`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]     perf_issue_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    issue_ctrl #(
        .ROB_DEPTH(c_DEPTH), .RS_DEPTH(c_DEPTH), .SLB_DEPTH(c_DEPTH),
        .CNT_WIDTH(c_CW), .RECOVER_CYCLES(c_RC)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .is_empty_from_instr_queue(empty), .is_sl_from_dc(is_sl),
        .rob_release(rob_rel), .rs_release(rs_rel), .slb_release(slb_rel),
        .pop_to_instr_queue(pop), .issue_to_rob(i_rob), .issue_to_rs(i_rs),
        .issue_to_slb(i_slb), .stall(stall), .rob_credit(rob_credit)
`ifdef ISSUE_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // ---------------- behavioural model ----------------
    int   m_rob = c_DEPTH, m_rs = c_DEPTH, m_slb = c_DEPTH;
    int   m_block = 0;          // remaining blocked cycles after a flush
    bit   m_prev_flush = 1'b0;  // previous enabled cycle saw flush high
    bit   m_iss;
    logic [31:0] m_pi = '0, m_ps = '0;

    function automatic bit exp_issue();
        return !rst && rdy && !flush && (m_block == 0) && !empty && (m_rob > 0) &&
               (is_sl ? (m_slb > 0) : (m_rs > 0));
    endfunction

    function automatic bit exp_stall();
        return !rst && rdy && !empty && !exp_issue();
    endfunction

    function automatic int clamp(input int v);
        return (v > c_DEPTH) ? c_DEPTH : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rob = c_DEPTH; m_rs = c_DEPTH; m_slb = c_DEPTH;
            m_block = 0; m_prev_flush = 1'b0; m_pi = '0; m_ps = '0;
        end else if (rdy) begin
            m_iss = exp_issue();
            if (m_iss) m_pi = m_pi + 32'd1;
            if (exp_stall()) m_ps = m_ps + 32'd1;
            if (flush || m_prev_flush) begin
                m_rob = c_DEPTH; m_rs = c_DEPTH; m_slb = c_DEPTH;
            end else begin
                m_rob = clamp(m_rob - int'(m_iss) + int'(rob_rel));
                m_rs  = clamp(m_rs - int'(m_iss && !is_sl) + int'(rs_rel));
                m_slb = clamp(m_slb - int'(m_iss && is_sl) + int'(slb_rel));
            end
            if (flush) m_block = c_BLOCK;
            else if (m_block > 0) m_block = m_block - 1;
            m_prev_flush = flush;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("pop", 32'(pop), 32'(exp_issue()));
        chk("issue_to_rob", 32'(i_rob), 32'(exp_issue()));
        chk("issue_to_rs", 32'(i_rs), 32'(exp_issue() && !is_sl));
        chk("issue_to_slb", 32'(i_slb), 32'(exp_issue() && is_sl));
        chk("stall", 32'(stall), 32'(exp_stall()));
        chk("rob_credit", 32'(rob_credit), 32'(m_rob));
`ifdef ISSUE_PERF_CNT_EN
        chk("perf_issue", perf_issue_cnt, m_pi);
        chk("perf_stall", perf_stall_cnt, m_ps);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #2;
        chk("reset pop", 32'(pop), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset rob_credit", 32'(rob_credit), 32'd16);
        tick(); tick();
        rst = 1'b0;

        // A: sixteen RS-bound issues drain ROB and RS credits
        rdy = 1'b1; empty = 1'b0; is_sl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("A issue", 32'(pop), 32'd1);
            tick();
        end
        settle();
        chk("A full stall", 32'(stall), 32'd1);
        chk("A full pop", 32'(pop), 32'd0);
        chk("A rob_credit", 32'(rob_credit), 32'd0);

        // B: RS full, one ROB entry returned, load/store head goes to SLB
        empty = 1'b1; rob_rel = 1'b1;
        tick();
        rob_rel = 1'b0; empty = 1'b0; is_sl = 1'b1;
        settle();
        chk("B slb issue", 32'(i_slb), 32'd1);
        chk("B rs quiet", 32'(i_rs), 32'd0);
        tick();
        settle();
        chk("B rob empty", 32'(pop), 32'd0);

        // C: RS release and RS-bound head in the same cycle
        empty = 1'b1; rob_rel = 1'b1;
        tick(); tick();
        rob_rel = 1'b0; empty = 1'b0; is_sl = 1'b0; rs_rel = 1'b1;
        settle();
        chk("C same-cycle pop", 32'(pop), 32'd0);
        chk("C same-cycle stall", 32'(stall), 32'd1);
        tick();
        rs_rel = 1'b0;
        settle();
        chk("C next issue_rs", 32'(i_rs), 32'd1);
        tick();
        settle();
        chk("C rs empty again", 32'(pop), 32'd0);

        // D: flush for three cycles from rob_credit=5
        empty = 1'b1; rob_rel = 1'b1;
        repeat (4) tick();
        rob_rel = 1'b0;
        settle();
        chk("D rob_credit 5", 32'(rob_credit), 32'd5);
        empty = 1'b0; is_sl = 1'b1; flush = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            rob_rel = k[0];
            settle();
            chk("D flush pop", 32'(pop), 32'd0);
            tick();
        end
        flush = 1'b0; rob_rel = 1'b0;
        for (int k = 4; k <= 5; k++) begin
            settle();
            chk("D recover pop", 32'(pop), 32'd0);
            if (k == 4) chk("D refilled", 32'(rob_credit), 32'd16);
            tick();
        end
        settle();
        chk("D resume cycle 6", 32'(i_slb), 32'd1);
        tick();

        // E: rdy low freezes everything and silences strobes
        rdy = 1'b0; rob_rel = 1'b1; rs_rel = 1'b1; slb_rel = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("E rdy0 pop", 32'(pop), 32'd0);
            chk("E rdy0 stall", 32'(stall), 32'd0);
            tick();
        end
        rob_rel = 1'b0; rs_rel = 1'b0; slb_rel = 1'b0; rdy = 1'b1;
        settle();
        chk("E rob_credit held", 32'(rob_credit), 32'd15);

        // F: async reset with credits at 3, then again mid-RECOVER
        repeat (12) tick();
        settle();
        chk("F rob_credit 3", 32'(rob_credit), 32'd3);
        chk("F pre-reset pop", 32'(pop), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("F async pop", 32'(pop), 32'd0);
        chk("F async rob_credit", 32'(rob_credit), 32'd16);
        tick();
        rst = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        settle();
        chk("F recover stall", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("F rst stall", 32'(stall), 32'd0);
        chk("F rst pop", 32'(pop), 32'd0);
        chk("F rst rob_credit", 32'(rob_credit), 32'd16);
`ifdef ISSUE_PERF_CNT_EN
        chk("F rst perf_issue", perf_issue_cnt, 32'd0);
        chk("F rst perf_stall", perf_stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        settle();
        chk("F post-reset issue", 32'(pop), 32'd1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
